// File: rtl/des_pkg.sv
// -----------------------------------------------------------------------------
// des_pkg
//   Shared types and constant tables for the DES key schedule.
//   - des_key_t / round_key_t / half_key_t use MSB-first (ascending) bit
//     numbering, so bit 0 is the leftmost bit as in the DES tables.
//   - PC1_TAB / PC2_TAB hold zero-based source bit positions.
//   - SHIFTS holds the left-rotate amount applied before each round key.
//   - ks_state_t enumerates the sequencer FSM states.
// -----------------------------------------------------------------------------
package des_pkg;

   typedef logic [0:63] des_key_t;
   typedef logic [0:47] round_key_t;
   typedef logic [0:27] half_key_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EXPAND = 2'd1,
      READY  = 2'd2,
      SERVE  = 2'd3
   } ks_state_t;

   // Permuted choice 1: 64-bit key -> 56-bit C||D (parity bits dropped).
   localparam int PC1_TAB [56] = '{
      56, 48, 40, 32, 24, 16,  8,  0, 57, 49, 41, 33, 25, 17,
       9,  1, 58, 50, 42, 34, 26, 18, 10,  2, 59, 51, 43, 35,
      62, 54, 46, 38, 30, 22, 14,  6, 61, 53, 45, 37, 29, 21,
      13,  5, 60, 52, 44, 36, 28, 20, 12,  4, 27, 19, 11,  3
   };

   // Permuted choice 2: 56-bit C||D -> 48-bit round key.
   localparam int PC2_TAB [48] = '{
      13, 16, 10, 23,  0,  4,  2, 27, 14,  5, 20,  9,
      22, 18, 11,  3, 25,  7, 15,  6, 26, 19, 12,  1,
      40, 51, 30, 36, 46, 54, 29, 39, 50, 44, 32, 47,
      43, 48, 38, 55, 33, 52, 45, 41, 49, 35, 28, 31
   };

   // Left-rotate amount per round (rounds 1, 2, 9 and 16 rotate by one).
   localparam logic [1:0] SHIFTS [16] = '{
      2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
      2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
   };

endpackage

// File: rtl/des_key_expand_step.sv
// -----------------------------------------------------------------------------
// des_key_expand_step
//   One combinational step of the DES key schedule: rotate both halves left
//   and derive the round key through PC2.
// Ports
//   c, d       in   current 28-bit halves
//   shift      in   rotate amount (2'd2 rotates by two, anything else by one)
//   c_next     out  rotated C half
//   d_next     out  rotated D half
//   round_key  out  PC2 of the rotated halves
// -----------------------------------------------------------------------------
module des_key_expand_step
   import des_pkg::*;
(
   input  half_key_t  c,
   input  half_key_t  d,
   input  logic [1:0] shift,
   output half_key_t  c_next,
   output half_key_t  d_next,
   output round_key_t round_key
);

   logic [0:55] cd_next;

   // Ascending bit order: a left rotate moves bit 0 to the far end.
   assign c_next = (shift == 2'd2) ? {c[2:27], c[0:1]} : {c[1:27], c[0]};
   assign d_next = (shift == 2'd2) ? {d[2:27], d[0:1]} : {d[1:27], d[0]};

   assign cd_next = {c_next, d_next};

   for (genvar i = 0; i < 48; i++) begin : g_pc2
      assign round_key[i] = cd_next[PC2_TAB[i]];
   end

endmodule

// File: rtl/des_round_key_sequencer.sv
// -----------------------------------------------------------------------------
// des_round_key_sequencer
//   Expands a DES key into 16 stored round keys (one per cycle) and serves
//   them to the round datapath, forward for encryption or reverse for
//   decryption. The stored schedule is reused until a new key is loaded.
// Ports
//   clk, rst    clock (rising edge) and asynchronous active-high reset
//   key_load    expand key_in; accepted while key_ready=1
//   key_in      64-bit DES key, MSB-first, parity bits ignored
//   key_ready   high in IDLE and READY
//   keys_valid  high while a complete schedule is stored
//   start       serve one block's schedule; accepted only in READY
//   decrypt     direction sampled with start (1 = K16..K1)
//   rk_valid    round_key/round_idx valid
//   rk_ack      datapath consumed the current key
//   round_key   current round key
//   round_idx   datapath round number 0..15 (direction independent)
//   done        one-cycle pulse after the last key is acknowledged
// -----------------------------------------------------------------------------
module des_round_key_sequencer
   import des_pkg::*;
#(
   parameter int ROUNDS = 16,
   parameter int RK_W   = 48
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_load,
   input  des_key_t   key_in,
   output logic       key_ready,
   output logic       keys_valid,
   input  logic       start,
   input  logic       decrypt,
   output logic       rk_valid,
   input  logic       rk_ack,
   output round_key_t round_key,
   output logic [3:0] round_idx,
   output logic       done
);

   if (ROUNDS != 16 || RK_W != 48) begin : g_param_check
      $error("des_round_key_sequencer supports only ROUNDS=16 and RK_W=48");
   end

   ks_state_t   state;
   half_key_t   c_q, d_q;
   half_key_t   c_nx, d_nx;
   round_key_t  rk_nx;
   round_key_t  store [ROUNDS];
   logic [3:0]  e_q;
   logic        dec_q;
   logic [0:55] cd_pc1;
   logic [3:0]  r_nx;
   logic [3:0]  slot_nx;

   for (genvar i = 0; i < 56; i++) begin : g_pc1
      assign cd_pc1[i] = key_in[PC1_TAB[i]];
   end

   des_key_expand_step u_step (
      .c         (c_q),
      .d         (d_q),
      .shift     (SHIFTS[e_q]),
      .c_next    (c_nx),
      .d_next    (d_nx),
      .round_key (rk_nx)
   );

   assign key_ready = (state == IDLE) || (state == READY);

   // Next key to present; 15-r is the bitwise complement of a 4-bit r.
   assign r_nx    = round_idx + 4'd1;
   assign slot_nx = dec_q ? ~r_nx : r_nx;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         c_q        <= '0;
         d_q        <= '0;
         e_q        <= '0;
         dec_q      <= 1'b0;
         keys_valid <= 1'b0;
         rk_valid   <= 1'b0;
         round_key  <= '0;
         round_idx  <= '0;
         done       <= 1'b0;
         // NOTE: the key store is deliberately reset so a reset leaves no
         // stale key material behind; this forces flops rather than RAM.
         store      <= '{default: '0};
      end else begin
         done <= 1'b0;
         case (state)
            IDLE, READY: begin
               // key_load has priority over start; start is simply dropped.
               if (key_load) begin
                  state      <= EXPAND;
                  {c_q, d_q} <= cd_pc1;
                  e_q        <= '0;
                  keys_valid <= 1'b0;
               end else if (start && (state == READY)) begin
                  state     <= SERVE;
                  dec_q     <= decrypt;
                  rk_valid  <= 1'b1;
                  round_idx <= '0;
                  round_key <= store[decrypt ? 4'd15 : 4'd0];
               end
            end
            EXPAND: begin
               c_q        <= c_nx;
               d_q        <= d_nx;
               store[e_q] <= rk_nx;
               e_q        <= e_q + 4'd1;
               if (e_q == 4'd15) begin
                  state      <= READY;
                  keys_valid <= 1'b1;
               end
            end
            SERVE: begin
               // rk_valid is always high in SERVE, so rk_ack alone is the handshake.
               if (rk_ack) begin
                  if (round_idx == 4'd15) begin
                     rk_valid <= 1'b0;
                     done     <= 1'b1;
                     state    <= READY;
                  end else begin
                     round_idx <= r_nx;
                     round_key <= store[slot_nx];
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
